// File: rtl/audio_i2s_clock_sequencer.sv
// audio_i2s_clock_sequencer
// Clock-management back end for the audio peripheral, running in the fast
// audio clock domain. It qualifies the MMCM lock through a shift-register
// sequencer that drives the gated fast-clock buffer CE. From that qualified
// clock it derives a registered 50 % duty I2S clock of period DIV, together
// with one-cycle rise and fall strobes.
// The block contains no clock primitives; it only drives their enables.

module audio_i2s_clock_sequencer #(
    parameter int SEQ_LEN = 8,   // lock-qualification depth, >= 1
    parameter int DIV     = 10   // fast-clock to I2S divide ratio, even and >= 2
) (
    input  logic clk_in1,
    input  logic RST,
    input  logic locked,
    output logic clk_en,
    output logic i2s_clk,
    output logic i2s_rise,
    output logic i2s_fall
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);

    logic [SEQ_LEN-1:0] seq_r;
    logic [SEQ_LEN-1:0] seq_nxt_s;
    logic [SEQ_LEN:0]   seq_ext_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               i2s_clk_r;
    logic               i2s_clk_nxt_s;
    logic               i2s_clk_d_r;

    // Shift the lock level into the qualification chain.
    // The chain is widened by one bit so that SEQ_LEN = 1 needs no special case.
    always_comb begin
        seq_ext_s = {seq_r, locked};
        seq_nxt_s = seq_ext_s[SEQ_LEN-1:0];
    end

    // Divider next state.
    // The divider is held at phase 0, with the clock low, whenever the clock
    // is not qualified. Otherwise it wraps at DIV-1.
    always_comb begin
        cnt_nxt_s     = CNT_ZERO;
        i2s_clk_nxt_s = 1'b0;
        if (clk_en) begin
            if (cnt_r == CNT_MAX) begin
                cnt_nxt_s = CNT_ZERO;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
            i2s_clk_nxt_s = (cnt_nxt_s >= CNT_HALF);
        end else begin
            cnt_nxt_s     = CNT_ZERO;
            i2s_clk_nxt_s = 1'b0;
        end
    end

    // State registers.
    // Reset is synchronous and overrides everything, including a period
    // that is in progress.
    always_ff @(posedge clk_in1) begin
        if (RST) begin
            seq_r       <= {SEQ_LEN{1'b0}};
            cnt_r       <= CNT_ZERO;
            i2s_clk_r   <= 1'b0;
            i2s_clk_d_r <= 1'b0;
        end else begin
            seq_r       <= seq_nxt_s;
            cnt_r       <= cnt_nxt_s;
            i2s_clk_r   <= i2s_clk_nxt_s;
            i2s_clk_d_r <= i2s_clk_r;
        end
    end

    // Outputs are either registers or decodes of registers, so there is no
    // path from locked.
    // Gating the fall strobe with clk_en hides the forced low edge that
    // occurs when qualification is lost.
    always_comb begin
        clk_en   = seq_r[SEQ_LEN-1];
        i2s_clk  = i2s_clk_r;
        i2s_rise = i2s_clk_r & ~i2s_clk_d_r;
        i2s_fall = ~i2s_clk_r & i2s_clk_d_r & seq_r[SEQ_LEN-1];
    end

endmodule

// File: tb/tb_audio_i2s_clock_sequencer.sv
// Testbench for audio_i2s_clock_sequencer.
// Two instances are driven by the same stimulus: the default (8, 10) and an
// override (2, 4). Every cycle, each instance is compared against a reference
// built from the behavioural rules:
//   - clk_en is the lock sample taken SEQ_LEN-1 edges earlier, or 0 when that
//     sample predates the latest reset;
//   - the divider phase is the number of consecutive enabled edges, modulo DIV.

module tb_audio_i2s_clock_sequencer;

    logic clk_in1 = 1'b0;
    logic RST     = 1'b1;
    logic locked  = 1'b0;

    logic a_en, a_clk, a_rise, a_fall;
    logic b_en, b_clk, b_rise, b_fall;

    int n_cmp = 0;
    int n_bad = 0;

    audio_i2s_clock_sequencer #(.SEQ_LEN(8), .DIV(10)) u_dut_a (
        .clk_in1  (clk_in1),
        .RST      (RST),
        .locked   (locked),
        .clk_en   (a_en),
        .i2s_clk  (a_clk),
        .i2s_rise (a_rise),
        .i2s_fall (a_fall)
    );

    audio_i2s_clock_sequencer #(.SEQ_LEN(2), .DIV(4)) u_dut_b (
        .clk_in1  (clk_in1),
        .RST      (RST),
        .locked   (locked),
        .clk_en   (b_en),
        .i2s_clk  (b_clk),
        .i2s_rise (b_rise),
        .i2s_fall (b_fall)
    );

    always #5 clk_in1 = ~clk_in1;

    // Reference model state; index 0 is instance a, index 1 is instance b.
    int  m_len [2] = '{8, 2};
    int  m_div [2] = '{10, 4};
    int  m_run [2];
    bit  m_clk [2];
    bit  m_clkd[2];
    bit  m_en  [2];
    bit  samp  [0:8191];
    int  last_rst = -1;
    int  edge_n   = -1;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_step(input logic rst_v, input logic lk_v);
        int idx;
        edge_n++;
        samp[edge_n] = !rst_v && lk_v;
        if (rst_v) last_rst = edge_n;
        for (int i = 0; i < 2; i++) begin
            if (rst_v) begin
                m_run[i]  = 0;
                m_clk[i]  = 1'b0;
                m_clkd[i] = 1'b0;
            end else begin
                m_clkd[i] = m_clk[i];
                if (m_en[i]) m_run[i] = m_run[i] + 1;
                else         m_run[i] = 0;
                m_clk[i] = ((m_run[i] % m_div[i]) >= (m_div[i] / 2));
            end
            idx = edge_n - m_len[i] + 1;
            m_en[i] = (idx > last_rst) ? samp[idx] : 1'b0;
        end
    endtask

    task automatic check_all();
        chk_val("a_clk_en",   a_en,   m_en[0]);
        chk_val("a_i2s_clk",  a_clk,  m_clk[0]);
        chk_val("a_i2s_rise", a_rise, m_clk[0] & ~m_clkd[0]);
        chk_val("a_i2s_fall", a_fall, ~m_clk[0] & m_clkd[0] & m_en[0]);
        chk_val("b_clk_en",   b_en,   m_en[1]);
        chk_val("b_i2s_clk",  b_clk,  m_clk[1]);
        chk_val("b_i2s_rise", b_rise, m_clk[1] & ~m_clkd[1]);
        chk_val("b_i2s_fall", b_fall, ~m_clk[1] & m_clkd[1] & m_en[1]);
    endtask

    // One clock: step the model on the edge, check on the falling edge, and
    // leave the caller free to change inputs there.
    task automatic tick();
        @(posedge clk_in1);
        model_step(RST, locked);
        @(negedge clk_in1);
        check_all();
    endtask

    // Count the edges after reset release until clk_en and i2s_clk first go
    // high, for both instances.
    task automatic measure_qual(output int qa, output int ca, output int qb, output int cb);
        qa = 0; ca = 0; qb = 0; cb = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (a_en  && qa == 0) qa = k;
            if (a_clk && ca == 0) ca = k;
            if (b_en  && qb == 0) qb = k;
            if (b_clk && cb == 0) cb = k;
        end
    endtask

    initial begin
        int qa, ca, qb, cb;
        int ra, fa, ha, rb, fb, hb, lo_a, lo_b;
        int lo_left;
        bit found;

        // Reset for 3 cycles, then lock.
        @(negedge clk_in1);
        RST = 1'b1; locked = 1'b1;
        repeat (3) tick();
        chk_val("reset_clk_en",  a_en,   1'b0);
        chk_val("reset_i2s_clk", a_clk,  1'b0);
        chk_val("reset_rise",    a_rise, 1'b0);
        chk_val("reset_fall",    a_fall, 1'b0);
        RST = 1'b0;
        measure_qual(qa, ca, qb, cb);
        chk_val("a_qual_edges",      qa, 8);
        chk_val("a_first_clk_edge",  ca, 13);
        chk_val("b_qual_edges",      qb, 2);
        chk_val("b_first_clk_edge",  cb, 4);

        // Steady state over a 100-cycle window.
        repeat (30) tick();
        ra = 0; fa = 0; ha = 0; rb = 0; fb = 0; hb = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            ra += a_rise; fa += a_fall; ha += a_clk;
            rb += b_rise; fb += b_fall; hb += b_clk;
        end
        chk_val("a_rise_count", ra, 10);
        chk_val("a_fall_count", fa, 10);
        chk_val("a_high_count", ha, 50);
        chk_val("b_rise_count", rb, 25);
        chk_val("b_fall_count", fb, 25);
        chk_val("b_high_count", hb, 50);

        // A one-cycle lock glitch produces a one-cycle clk_en gap.
        locked = 1'b0;
        tick();
        locked = 1'b1;
        lo_a = 0; lo_b = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            lo_a += !a_en; lo_b += !b_en;
        end
        chk_val("a_glitch_low_len", lo_a, 1);
        chk_val("b_glitch_low_len", lo_b, 1);

        // Lose lock permanently while i2s_clk is high.
        // Dropping right after a fall strobe makes qualification end while
        // the clock is high.
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (a_fall) found = 1'b1;
        end
        chk_val("wait_fall_timeout", found, 1'b1);
        locked = 1'b0;
        fa = 0;
        for (int k = 0; k < 8; k++) tick();
        chk_val("a_clk_high_at_drop", a_clk, 1'b1);
        for (int k = 0; k < 30; k++) begin
            tick();
            fa += a_fall;
        end
        chk_val("a_no_fall_after_drop", fa, 0);
        chk_val("a_en_after_drop",      a_en, 1'b0);
        chk_val("a_clk_after_drop",     a_clk, 1'b0);

        // Reset in the middle of a high phase.
        // Two cycles after a rise, the counter is at 7.
        locked = 1'b1;
        repeat (10) tick();
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (a_rise) found = 1'b1;
        end
        chk_val("wait_rise_timeout", found, 1'b1);
        repeat (2) tick();
        RST = 1'b1;
        tick();
        chk_val("midreset_clk",  a_clk, 1'b0);
        chk_val("midreset_en",   a_en,  1'b0);
        RST = 1'b0;
        measure_qual(qa, ca, qb, cb);
        chk_val("a_requal_edges",     qa, 8);
        chk_val("a_requal_first_clk", ca, 13);

        // Randomized lock glitches and occasional resets.
        lo_left = 0;
        for (int it = 0; it < 1500; it++) begin
            RST = ($urandom_range(0, 99) < 2);
            if (lo_left > 0) begin
                locked = 1'b0;
                lo_left--;
            end else if ($urandom_range(0, 99) < 4) begin
                locked = 1'b0;
                lo_left = $urandom_range(0, 11);
            end else begin
                locked = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
